// File: rtl/cordic_rotate_sched.sv
// Scan a 1-bpp source image, rotate each set pixel through the shared
// CORDIC core, and plot the rounded, clipped result into the frame buffer.
module cordic_rotate_sched #(
  parameter int W_BITS  = 4,
  parameter int H_BITS  = 4,
  parameter int FRAC    = 4,
  parameter int COORD_W = 12,
  parameter int ANGLE_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ANGLE_W-1:0]        theta,
  output logic                      busy,
  output logic                      done,
  output logic [W_BITS+H_BITS:0]    clip_cnt,
  output logic                      cor_valid,
  input  logic                      cor_ready,
  output logic [COORD_W-1:0]        cor_x,
  output logic [COORD_W-1:0]        cor_y,
  output logic [ANGLE_W-1:0]        cor_theta,
  input  logic                      res_valid,
  input  logic [COORD_W-1:0]        res_x,
  input  logic [COORD_W-1:0]        res_y,
  output logic [W_BITS+H_BITS-1:0]  src_addr,
  input  logic                      src_data,
  output logic                      dst_we,
  output logic [W_BITS+H_BITS-1:0]  dst_addr,
  output logic                      dst_data
);

  localparam int IMG_W = 1 << W_BITS;
  localparam int IMG_H = 1 << H_BITS;
  localparam int PIX_W = W_BITS + H_BITS;

  localparam logic signed [COORD_W-1:0] CTR_W = COORD_W'(IMG_W / 2);
  localparam logic signed [COORD_W-1:0] CTR_H = COORD_W'(IMG_H / 2);
  localparam logic signed [COORD_W:0] HALF  = (COORD_W+1)'(1 << (FRAC - 1));
  localparam logic signed [COORD_W:0] OFF_W = (COORD_W+1)'(IMG_W / 2);
  localparam logic signed [COORD_W:0] OFF_H = (COORD_W+1)'(IMG_H / 2);
  localparam logic signed [COORD_W:0] LIM_W = (COORD_W+1)'(IMG_W);
  localparam logic signed [COORD_W:0] LIM_H = (COORD_W+1)'(IMG_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state, state_d;

  logic [PIX_W-1:0]         cnt;
  logic [ANGLE_W-1:0]       theta_q;
  logic signed [COORD_W:0]  col_q, row_q;
  logic signed [COORD_W:0]  col_n, row_n;
  logic signed [COORD_W:0]  rx, ry;
  logic signed [COORD_W-1:0] cx, cy;
  logic                     last;
  logic                     in_frame;

  assign last      = &cnt;
  assign cor_theta = theta_q;

  // Centre the scan position; rotated result is rounded and un-centred.
  always_comb begin
    cx = $signed(COORD_W'(cnt[W_BITS-1:0])) - CTR_W;
    cy = $signed(COORD_W'(cnt[PIX_W-1:W_BITS])) - CTR_H;
    rx = {res_x[COORD_W-1], res_x};
    ry = {res_y[COORD_W-1], res_y};
    col_n = ((rx + HALF) >>> FRAC) + OFF_W;
    row_n = ((ry + HALF) >>> FRAC) + OFF_H;
    in_frame = !col_q[COORD_W] && (col_q < LIM_W) &&
               !row_q[COORD_W] && (row_q < LIM_H);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next state and strobes; every output idles low.
  always_comb begin
    state_d   = state;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    cor_valid = 1'b0;
    src_addr  = '0;
    dst_we    = 1'b0;
    dst_addr  = '0;
    dst_data  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        dst_we   = 1'b1;
        dst_addr = cnt;
        if (last) state_d = S_FETCH;
      end
      S_FETCH: begin
        src_addr = cnt;
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        if (src_data)  state_d = S_ISSUE;
        else if (last) state_d = S_DONE;
        else           state_d = S_FETCH;
      end
      S_ISSUE: begin
        cor_valid = 1'b1;
        if (cor_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (res_valid) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (in_frame) begin
          dst_we   = 1'b1;
          dst_addr = {row_q[H_BITS-1:0], col_q[W_BITS-1:0]};
          dst_data = 1'b1;
        end
        state_d = last ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pixel counter, captured operands, rounded result and clip count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      theta_q  <= '0;
      clip_cnt <= '0;
      cor_x    <= '0;
      cor_y    <= '0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            theta_q  <= theta;
            clip_cnt <= '0;
            cnt      <= '0;
          end
        end
        S_CLEAR: cnt <= cnt + PIX_W'(1);
        S_CHECK: begin
          if (src_data) begin
            cor_x <= cx <<< FRAC;
            cor_y <= cy <<< FRAC;
          end else begin
            cnt <= cnt + PIX_W'(1);
          end
        end
        S_WAIT: begin
          if (res_valid) begin
            col_q <= col_n;
            row_q <= row_n;
          end
        end
        S_WRITE: begin
          cnt <= cnt + PIX_W'(1);
          if (!in_frame && !(&clip_cnt))
            clip_cnt <= clip_cnt + (PIX_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
